fifo_gray: RTL and testbench

Single-clock synchronous FIFO whose read and write pointers are kept in Gray code. The full and empty flags are derived by comparing those pointers. It is a drop-in buffering element for datapaths in one clock domain. Its pointer format matches the team's asynchronous-FIFO pointer logic, so that logic can later be split across domains without changing the pointer encoding.

---
 rtl/fifo_gray_pkg.sv | 14 +
 rtl/fifo_gray_ptr.sv | 32 +++
 rtl/fifo_gray.sv | 81 ++++++++
 tb/tb_fifo_gray.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fifo_gray_pkg.sv
// Shared helpers for Gray-coded FIFO pointers: pointer width and Gray encoding.
package fifo_gray_pkg;

  // Address width for a power-of-two depth.
  function automatic int ptr_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Binary to reflected Gray code. Callers size the argument and result by cast.
  function automatic logic [31:0] gray_enc(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary pointer with a registered Gray copy, both AW+1 bits wide.
// The extra MSB is the wrap bit that lets full be told apart from empty.
module gray_ptr
  import fifo_gray_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [AW:0] bin,
  output logic [AW:0] gray
);

  logic [AW:0] bin_nxt;
  logic [AW:0] gray_nxt;

  assign bin_nxt  = bin + (AW+1)'(1);
  assign gray_nxt = (AW+1)'(gray_enc(32'(bin_nxt)));

  // Advance binary and Gray copies together so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
    end else if (inc) begin
      bin  <= bin_nxt;
      gray <= gray_nxt;
    end
  end

endmodule

// File: rtl/fifo_gray.sv
// Single-clock FIFO with Gray-coded pointers. Flags come from comparing
// the registered Gray pointers, so the pointer format matches the async FIFO.
module fifo_gray
  import fifo_gray_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = ptr_aw(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wbin;
  logic [AW:0]           wgray;
  logic [AW:0]           rbin;
  logic [AW:0]           rgray;
  logic                  wr_en;
  logic                  rd_en;
  logic                  unused_wrap;

  // Requests are qualified by the flags as they stand before the edge.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // The binary wrap bits are only needed through their Gray copies.
  assign unused_wrap = wbin[AW] ^ rbin[AW];

  gray_ptr #(.AW(AW)) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (wr_en),
    .bin  (wbin),
    .gray (wgray)
  );

  gray_ptr #(.AW(AW)) u_rptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (rd_en),
    .bin  (rbin),
    .gray (rgray)
  );

  // Empty when the Gray pointers match exactly.
  assign empty = (wgray == rgray);

  // Full when the pointers are one lap apart: in Gray code the top two bits differ.
  generate
    if (AW == 1) begin : g_full_aw1
      assign full = (wgray == ~rgray);
    end else begin : g_full_awn
      assign full = (wgray == {~rgray[AW:AW-1], rgray[AW-2:0]});
    end
  endgenerate

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wbin[AW-1:0]] <= data_in;
    end
  end

  // Registered read port; holds its value until the next accepted pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_en) begin
      data_out <= mem[rbin[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_fifo_gray.sv
// Self-checking bench for fifo_gray against a queue-based reference model.
module tb_fifo_gray;

  localparam int DW  = 8;
  localparam int DEP = 16;

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  fifo_gray #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout;
  logic [DW-1:0] cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == DEP));
    check({tag, ".dout"},  32'(data_out), 32'(exp_dout));
  endtask

  // One clock with the given requests; model updates with pre-edge occupancy.
  task automatic step(input string tag, input logic p, input logic r, input logic [DW-1:0] d);
    bit acc_push;
    bit acc_pop;
    push    = p;
    pop     = r;
    data_in = d;
    acc_push = p && (model_q.size() < DEP);
    acc_pop  = r && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (acc_pop)  exp_dout = model_q.pop_front();
    if (acc_push) model_q.push_back(d);
    push = 1'b0;
    pop  = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input int n, input logic p);
    rst  = 1'b1;
    push = p;
    pop  = 1'b0;
    data_in = 8'h5A;
    repeat (n) @(posedge clk);
    #1;
    rst  = 1'b0;
    push = 1'b0;
    model_q.delete();
    exp_dout = '0;
    check_state("reset");
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0; exp_dout = '0; cnt = '0;

    // Reset and idle
    do_reset(2, 1'b0);
    step("idle", 1'b0, 1'b0, 8'h00);

    // Fill with 0x01..0x10, then an ignored push of 0xFF
    for (int i = 1; i <= DEP; i++) step("fill", 1'b1, 1'b0, DW'(i));
    check("full_after_fill", 32'(full), 32'd1);
    step("overflow", 1'b1, 1'b0, 8'hFF);

    // Drain in order, then an ignored pop
    for (int i = 1; i <= DEP; i++) begin
      step("drain", 1'b0, 1'b1, 8'h00);
      check("drain_order", 32'(data_out), 32'(i));
    end
    step("underflow", 1'b0, 1'b1, 8'h00);
    check("underflow_hold", 32'(data_out), 32'h10);

    // Simultaneous push+pop while holding 8 words
    for (int i = 0; i < 8; i++) step("load8", 1'b1, 1'b0, 8'h20 + DW'(i));
    for (int i = 0; i < 6; i++) step("pp8", 1'b1, 1'b1, 8'h40 + DW'(i));
    check("occupancy8", 32'(model_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) step("unload8", 1'b0, 1'b1, 8'h00);

    // Simultaneous when empty: only push takes effect, no fall-through
    step("pp_empty", 1'b1, 1'b1, 8'h77);
    check("pp_empty_nofall", 32'(data_out), 32'(exp_dout));
    step("pop_77", 1'b0, 1'b1, 8'h00);
    check("pp_empty_word", 32'(data_out), 32'h77);

    // Simultaneous when full: only pop takes effect
    for (int i = 0; i < DEP; i++) step("refill", 1'b1, 1'b0, 8'h80 + DW'(i));
    step("pp_full", 1'b1, 1'b1, 8'hEE);
    check("pp_full_pop", 32'(data_out), 32'h80);
    for (int i = 0; i < DEP; i++) step("flush", 1'b0, 1'b1, 8'h00);

    // Wrap-around: interleaved counter pattern crossing pointer rollover
    for (int i = 0; i < 40; i++) begin
      step("wrap", 1'b1, (i % 3) != 0, cnt);
      cnt++;
    end
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cnt);
      cnt++;
    end

    // Reset mid-operation with 5 words stored and a push at the reset edge
    while (model_q.size() > 0) step("pre_rst", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step("load5", 1'b1, 1'b0, 8'h10 + DW'(i));
    do_reset(1, 1'b1);
    step("post_push", 1'b1, 1'b0, 8'hA5);
    step("post_pop", 1'b0, 1'b1, 8'h00);
    check("post_rst_a5", 32'(data_out), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
